des_request_scheduler: RTL
==========================

Name: des_request_scheduler

Overview:
- Shares one des_core between NUM_REQ independent requesters.
- Grants requesters round-robin and registers the winner's plaintext and key.
- Fires the core's start strobe, waits for done with a timeout watchdog, and returns ciphertext plus status on one shared response channel tagged with the requester ID.
- Sits between the processing-element request ports and des_core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- TIMEOUT_CYCLES, 32, cycles allowed in WAIT for done before a timeout error is declared; must be greater than core latency (16 rounds).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid_din  in  NUM_REQ  request pending, one bit per requester.
- req_plaintext_din  in  64*NUM_REQ  plaintexts; requester i occupies bits [64*i +: 64].
- req_key_din  in  64*NUM_REQ  keys, same packing as plaintexts.
- req_ready_dout  out  NUM_REQ  one-hot accept pulse.
- resp_valid_dout  out  1  response available.
- resp_ready_din  in  1  response consumed.
- resp_id_dout  out  ID_W  ID of the requester served.
- resp_ciphertext_dout  out  64  result; 0 on timeout.
- resp_parity_dout  out  1  core parity_check captured at launch.
- resp_timeout_dout  out  1  done did not arrive within TIMEOUT_CYCLES.
- des_start_strobe_dout  out  1  to core start_strobe_din.
- des_plaintext_dout  out  64  to core, registered.
- des_key_dout  out  64  to core, registered.
- des_done_strobe_din  in  1  from core.
- des_active_din  in  1  from core.
- des_parity_check_din  in  1  from core.
- des_ciphertext_din  in  64  from core.
- busy_dout  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, rr pointer=0, timeout counter=0.
  - All outputs 0, including the plaintext/key registers.
  - A reset mid-operation abandons the transaction with no response; the core shares the same reset.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set and des_active_din=0, grant the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Same cycle: req_ready_dout[g]=1 for exactly one cycle; on the edge, latch plaintext, key and g; pointer <= (g+1) mod NUM_REQ.
  - Next state LAUNCH.
  - If des_active_din=1, no grant is made (guards against a stale core).
- LAUNCH:
  - des_start_strobe_dout=1 for exactly one cycle.
  - Capture des_parity_check_din (the key register is already stable).
  - Clear timeout counter; next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - If des_done_strobe_din=1: latch des_ciphertext_din, set timeout flag=0, next state RESP.
  - Else if counter reaches TIMEOUT_CYCLES-1: ciphertext=0, timeout flag=1, next state RESP.
  - If done and the last timeout cycle coincide, done wins.
- RESP:
  - resp_valid_dout=1 with ID, ciphertext and flags held stable until resp_ready_din=1 at a clock edge, then IDLE.
  - resp_ready_din while resp_valid=0 is ignored.
- des_done_strobe_din outside WAIT is ignored and produces no response.
- des_plaintext_dout and des_key_dout are held constant from LAUNCH until the next grant.
- req_valid dropping before grant: no accept; dropping after accept: no effect.
- Latency with resp_ready held 1:
  - accept at cycle t; start strobe at t+1.
  - resp_valid one cycle after the done strobe, i.e. t+1+L_core+1.
  - Back-to-back grant earliest the cycle after the response handshake.
- No new request is accepted while a response is pending (single outstanding transaction).
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0.

Decomposition:
- Shared include des_sched_defines.vh holds: state encodings (2 bits), DEFAULT_TIMEOUT, and the plaintext/key slice macro for packed buses.
- One sub-module, rr_arbiter: parameter NUM_REQ; inputs req vector, pointer, enable; outputs one-hot grant and encoded grant index. Purely combinational.
- The pointer register lives in des_request_scheduler.

Test Plan:
- Single request: requester 1, key 133457799BBCDFF1, plaintext 0123456789ABCDEF, real des_core -> resp_id=1, ciphertext 85E813540F0AB405, timeout=0, exactly one start strobe.
- Round-robin: all 4 requesters valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0; each req_ready is a single-cycle pulse.
- Second vector with backpressure: requester 3, key 0E329232EA6D0D73, plaintext 8787878787878787, resp_ready low 10 cycles -> ciphertext 0000000000000000 held stable with resp_valid=1 all 10 cycles; no new grant until the handshake.
- Timeout: core model never asserts done, TIMEOUT_CYCLES=32 -> resp_valid exactly 32 cycles after the start strobe, ciphertext=0, timeout=1.
- Reset mid-WAIT: reset=0 for 2 cycles at cycle 8 of WAIT -> all outputs 0, no response emitted, next grant starts from requester 0.
- Spurious done in IDLE, and done coincident with the final timeout cycle -> first is ignored; second reports core ciphertext with timeout=0.

Source files
------------

// File: rtl/des_request_scheduler_pkg.sv
// Shared definitions for the DES request scheduler: FSM encoding, block width,
// default watchdog length and the round-robin pointer advance.
package des_request_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } sched_state_t;

    localparam int BLK_W           = 64;
    localparam int DEFAULT_TIMEOUT = 32;

    function automatic int next_ptr(input int grant, input int num_req);
        return (grant == num_req - 1) ? 0 : grant + 1;
    endfunction

endpackage

// File: rtl/des_request_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer,
// wrapping modulo NUM_REQ, produces a one-hot grant and its index.
module des_request_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        if (i_enable) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_cand = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
                if (!w_found && i_req[w_cand]) begin
                    w_found          = 1'b1;
                    o_grant[w_cand]  = 1'b1;
                    o_grant_idx      = w_cand;
                end
            end
        end
    end

endmodule

// File: rtl/des_request_scheduler.sv
// Shares one des_core among NUM_REQ requesters: round-robin grant, launch,
// watchdog-bounded wait for done, and a single tagged response channel.
module des_request_scheduler
    import des_request_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid_din,
    input  logic [BLK_W*NUM_REQ-1:0] req_plaintext_din,
    input  logic [BLK_W*NUM_REQ-1:0] req_key_din,
    output logic [NUM_REQ-1:0]       req_ready_dout,
    output logic                     resp_valid_dout,
    input  logic                     resp_ready_din,
    output logic [ID_W-1:0]          resp_id_dout,
    output logic [BLK_W-1:0]         resp_ciphertext_dout,
    output logic                     resp_parity_dout,
    output logic                     resp_timeout_dout,
    output logic                     des_start_strobe_dout,
    output logic [BLK_W-1:0]         des_plaintext_dout,
    output logic [BLK_W-1:0]         des_key_dout,
    input  logic                     des_done_strobe_din,
    input  logic                     des_active_din,
    input  logic                     des_parity_check_din,
    input  logic [BLK_W-1:0]         des_ciphertext_din,
    output logic                     busy_dout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    sched_state_t     r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [CNT_W-1:0] r_cnt;
    logic [BLK_W-1:0] r_pt;
    logic [BLK_W-1:0] r_key;
    logic [BLK_W-1:0] r_ct;
    logic             r_start;
    logic             r_resp_valid;
    logic             r_parity;
    logic             r_timeout;
    logic             r_busy;

    logic               w_enable;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_timeout_hit;

    // A still-active core means a stale operation; hold off granting until it clears.
    assign w_enable      = reset && (r_state == ST_IDLE) && !des_active_din;
    assign w_cnt_next    = r_cnt + CNT_W'(1);
    assign w_timeout_hit = (w_cnt_next == CNT_W'(TIMEOUT_CYCLES - 1));

    des_request_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_arbiter (
        .i_req       (req_valid_din),
        .i_ptr       (r_ptr),
        .i_enable    (w_enable),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_pt         <= '0;
            r_key        <= '0;
            r_ct         <= '0;
            r_start      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_parity     <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_id    <= w_grant_idx;
                        r_pt    <= req_plaintext_din[BLK_W*w_grant_idx +: BLK_W];
                        r_key   <= req_key_din[BLK_W*w_grant_idx +: BLK_W];
                        r_ptr   <= ID_W'(next_ptr(int'(w_grant_idx), NUM_REQ));
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_parity <= des_parity_check_din;
                    r_cnt    <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= w_cnt_next;
                    // Done takes priority over a watchdog expiring in the same cycle.
                    if (des_done_strobe_din) begin
                        r_ct         <= des_ciphertext_din;
                        r_timeout    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (w_timeout_hit) begin
                        r_ct         <= '0;
                        r_timeout    <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_din) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_dout        = w_grant;
    assign resp_valid_dout       = r_resp_valid;
    assign resp_id_dout          = r_id;
    assign resp_ciphertext_dout  = r_ct;
    assign resp_parity_dout      = r_parity;
    assign resp_timeout_dout     = r_timeout;
    assign des_start_strobe_dout = r_start;
    assign des_plaintext_dout    = r_pt;
    assign des_key_dout          = r_key;
    assign busy_dout             = r_busy;

endmodule
